// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit dynamic branch predictor.
// Holds the counter encoding for the default 2-bit case, the PC index/tag
// extraction helpers and the saturating increment used by the statistics
// counters. The helpers work on a 64-bit view of the PC so that any
// PC_WIDTH up to 64 can use them; callers size-cast the result.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'd1;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'd2;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'd3;  // strongly taken

    // Word-aligned PCs: bits [1:0] never select an entry.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int index_bits);
        return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

    function automatic logic [31:0] stat_inc(input logic [31:0] cnt, input logic en);
        return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one CTR_BITS-wide up/down saturating counter.
// Ports:
//   ctr_cur  current counter value
//   up       1: increment (branch taken), 0: decrement (not taken)
//   ctr_upd  updated value, holding at all-ones and at zero
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_cur,
    input  logic                up,
    output logic [CTR_BITS-1:0] ctr_upd
);

    always_comb begin
        ctr_upd = ctr_cur;
        if (up) begin
            if (ctr_cur != {CTR_BITS{1'b1}}) ctr_upd = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != '0) ctr_upd = ctr_cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor_2bit.sv
// Dynamic branch predictor: table of saturating direction counters plus a
// tagged branch target buffer, both indexed by pc[INDEX_BITS+1:2].
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   if_valid, if_pc       fetch lookup request
//   pred_taken/target     same-cycle prediction (target = if_pc+4 when not taken)
//   res_*                 MEM-stage resolution of one branch; trains on the edge
//   mispredict/correct_pc redirect request and redirect PC
//   branch_cnt/mispred_cnt saturating statistics
module branch_predictor_2bit
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int CTR_BITS   = 2,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    input  logic                res_valid,
    input  logic [PC_WIDTH-1:0] res_pc,
    input  logic                res_taken,
    input  logic [PC_WIDTH-1:0] res_target,
    input  logic                res_pred_taken,
    input  logic [PC_WIDTH-1:0] res_pred_target,
    output logic                mispredict,
    output logic [PC_WIDTH-1:0] correct_pc,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispred_cnt
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] ctr        [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid;
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] btb_target [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, res_idx;
    logic [TAG_BITS-1:0]   if_tag, res_tag;
    logic                  hit;
    logic [CTR_BITS-1:0]   ctr_upd;

    assign if_idx  = INDEX_BITS'(pc_index(64'(if_pc), INDEX_BITS));
    assign if_tag  = TAG_BITS'(pc_tag(64'(if_pc), INDEX_BITS));
    assign res_idx = INDEX_BITS'(pc_index(64'(res_pc), INDEX_BITS));
    assign res_tag = TAG_BITS'(pc_tag(64'(res_pc), INDEX_BITS));

    // A taken direction with no BTB hit has no usable target, so it
    // falls back to not-taken.
    assign hit         = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign pred_taken  = if_valid && hit && ctr[if_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? btb_target[if_idx] : if_pc + PC_WIDTH'(4);

    assign mispredict = res_valid &&
                        ((res_taken != res_pred_taken) ||
                         (res_taken && (res_target != res_pred_target)));
    assign correct_pc = res_taken ? res_target : res_pc + PC_WIDTH'(4);

    sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr_update (
        .ctr_cur (ctr[res_idx]),
        .up      (res_taken),
        .ctr_upd (ctr_upd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
            btb_valid   <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (res_valid) begin
                ctr[res_idx] <= ctr_upd;
                if (res_taken) btb_valid[res_idx] <= 1'b1;
            end
            branch_cnt  <= stat_inc(branch_cnt, res_valid);
            mispred_cnt <= stat_inc(mispred_cnt, mispredict);
        end
    end

    // Tag/target payload needs no reset: it is only observed behind btb_valid.
    always_ff @(posedge clk) begin
        if (rst_n && res_valid && res_taken) begin
            btb_tag[res_idx]    <= res_tag;
            btb_target[res_idx] <= res_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor_2bit.sv
module tb_branch_predictor_2bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor_2bit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    localparam logic [31:0] PC_A = 32'h0040_0010;  // index 4, tag 0x400
    localparam logic [31:0] PC_B = 32'h0040_1010;  // index 4, tag 0x401
    localparam logic [31:0] PC_C = 32'h0040_0020;  // index 8
    localparam logic [31:0] PC_D = 32'h0040_0030;  // index 12
    localparam logic [31:0] T_A  = 32'h0040_0100;
    localparam logic [31:0] T_B  = 32'h0040_2000;

    typedef struct {
        string       name;
        bit          cp;
        logic        ept;
        logic [31:0] eptg;
        bit          cr;
        logic        emis;
        logic [31:0] ecpc;
        bit          cs;
        logic [31:0] ebc;
        logic [31:0] emc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t mon;
    bit   probe = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: consumes one expectation each cycle the stimulus marks as observed.
    always @(negedge clk) begin
        if (probe) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                mon = q.pop_front();
                if (mon.cp) begin
                    chk({mon.name, ".pred_taken"},  32'(pred_taken), 32'(mon.ept));
                    chk({mon.name, ".pred_target"}, pred_target,     mon.eptg);
                end
                if (mon.cr) begin
                    chk({mon.name, ".mispredict"}, 32'(mispredict), 32'(mon.emis));
                    if (mon.emis) chk({mon.name, ".correct_pc"}, correct_pc, mon.ecpc);
                end
                if (mon.cs) begin
                    chk({mon.name, ".branch_cnt"},  branch_cnt,  mon.ebc);
                    chk({mon.name, ".mispred_cnt"}, mispred_cnt, mon.emc);
                end
            end
        end
    end

    task automatic drive(input logic ifv, input logic [31:0] ifpc,
                         input logic rv, input logic [31:0] rpc, input logic rt,
                         input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt);
        @(posedge clk);
        #1;
        probe           = 1'b0;
        if_valid        = ifv;
        if_pc           = ifpc;
        res_valid       = rv;
        res_pc          = rpc;
        res_taken       = rt;
        res_target      = rtgt;
        res_pred_taken  = rpt;
        res_pred_target = rptgt;
        cur.cp = 1'b0;
        cur.cr = 1'b0;
        cur.cs = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic exp_pred(input logic t, input logic [31:0] tgt);
        cur.cp = 1'b1; cur.ept = t; cur.eptg = tgt;
    endtask

    task automatic exp_res(input logic m, input logic [31:0] cpc);
        cur.cr = 1'b1; cur.emis = m; cur.ecpc = cpc;
    endtask

    task automatic exp_stats(input logic [31:0] bc, input logic [31:0] mc);
        cur.cs = 1'b1; cur.ebc = bc; cur.emc = mc;
    endtask

    task automatic commit(input string nm);
        cur.name = nm;
        q.push_back(cur);
        probe = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        idle();

        lookup(PC_A); rst_n = 1'b1;
        exp_pred(1'b0, PC_A + 32'd4); exp_stats(32'd0, 32'd0); commit("reset_lookup");

        // First taken resolution; same-cycle lookup sees untrained entry.
        drive(1'b1, PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b0, PC_A + 32'd4);
        exp_pred(1'b0, PC_A + 32'd4); exp_res(1'b1, T_A); commit("first_taken");

        lookup(PC_A);
        exp_pred(1'b1, T_A); exp_stats(32'd1, 32'd1); commit("trained_lookup");

        // ctr 10 -> 11 -> 11 -> 11, correctly predicted.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b1, T_A);
            exp_pred(1'b1, T_A); exp_res(1'b0, 32'h0); commit($sformatf("taken_%0d", i));
        end

        // ctr 11 -> 10 -> 01
        drive(1'b1, PC_A, 1'b1, PC_A, 1'b0, T_A, 1'b1, T_A);
        exp_pred(1'b1, T_A); exp_res(1'b1, PC_A + 32'd4); commit("not_taken_1");

        drive(1'b1, PC_A, 1'b1, PC_A, 1'b0, T_A, 1'b1, T_A);
        exp_pred(1'b1, T_A); exp_res(1'b1, PC_A + 32'd4); commit("not_taken_2");

        lookup(PC_A);
        exp_pred(1'b0, PC_A + 32'd4); exp_stats(32'd6, 32'd3); commit("after_two_nt");

        // Aliasing on index 4.
        drive(1'b0, 32'h0, 1'b1, PC_A, 1'b1, T_A, 1'b0, PC_A + 32'd4);
        exp_res(1'b1, T_A); commit("retrain_A");

        lookup(PC_B);
        exp_pred(1'b0, PC_B + 32'd4); commit("alias_miss");

        drive(1'b0, 32'h0, 1'b1, PC_B, 1'b1, T_B, 1'b0, PC_B + 32'd4);
        exp_res(1'b1, T_B); commit("train_B");

        lookup(PC_B);
        exp_pred(1'b1, T_B); commit("B_hit");

        lookup(PC_A);
        exp_pred(1'b0, PC_A + 32'd4); commit("A_evicted");

        // Target mispredict; same-cycle lookup returns the old target.
        drive(1'b1, PC_B, 1'b1, PC_B, 1'b1, 32'h200, 1'b1, 32'h100);
        exp_pred(1'b1, T_B); exp_res(1'b1, 32'h200); commit("target_mispredict");

        lookup(PC_B);
        exp_pred(1'b1, 32'h200); commit("new_target");

        drive(1'b0, 32'h0, 1'b1, PC_C, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_res(1'b0, 32'h0); commit("nt_correct");

        // Mismatched fields with res_valid low must not flag a mispredict.
        drive(1'b0, 32'h0, 1'b0, PC_C, 1'b1, 32'h300, 1'b0, 32'h0);
        exp_res(1'b0, 32'h0); exp_stats(32'd10, 32'd6); commit("stats_mid");

        // Reset coinciding with a resolution: training discarded.
        drive(1'b1, PC_D, 1'b1, PC_D, 1'b1, 32'h0050_0000, 1'b0, PC_D + 32'd4);
        rst_n = 1'b0;
        exp_pred(1'b0, PC_D + 32'd4); exp_res(1'b1, 32'h0050_0000); commit("reset_with_res");

        lookup(PC_D); rst_n = 1'b1;
        exp_pred(1'b0, PC_D + 32'd4); exp_stats(32'd0, 32'd0); commit("post_reset_D");

        lookup(PC_B);
        exp_pred(1'b0, PC_B + 32'd4); commit("post_reset_B");

        drive(1'b0, 32'h0, 1'b1, PC_B, 1'b1, T_B, 1'b0, PC_B + 32'd4);
        exp_res(1'b1, T_B); commit("retrain_B");

        drive(1'b0, PC_B, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_pred(1'b0, PC_B + 32'd4); commit("if_valid_low");

        lookup(PC_B);
        exp_pred(1'b1, T_B); commit("B_hit_again");

        // Statistics saturation.
        drive(1'b0, 32'h0, 1'b1, PC_B, 1'b1, T_B, 1'b0, PC_B + 32'd4);
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        exp_res(1'b1, T_B); commit("mispred_at_max");

        idle();
        release dut.mispred_cnt;
        exp_stats(32'd2, 32'hFFFF_FFFF); commit("mispred_saturated");

        idle();
        idle();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
